// File: rtl/alarm_controller.sv
// Car-alarm sequencer: arm/disarm from key-fob requests, exit and entry delays,
// siren timing and the lights-on warning chime.
module alarm_controller #(
    parameter int unsigned EXIT_DLY   = 8,
    parameter int unsigned ENTRY_DLY  = 8,
    parameter int unsigned SIREN_LEN  = 16,
    parameter int unsigned CHIME_HALF = 2,
    parameter int unsigned CW         = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       IgnitionSignalOn,
    input  logic       OpenDoorSign,
    input  logic       PassiveSignal,
    input  logic       ArmRequest,
    input  logic       DisarmRequest,
    output logic       Siren,
    output logic       LightsFlash,
    output logic       Chime,
    output logic       ArmedLed,
    output logic       ArmReject,
    output logic [3:0] AlarmCount,
    output logic [2:0] State
);

    localparam int unsigned PW = $clog2(2 * CHIME_HALF + 1);

    typedef enum logic [2:0] {
        StDisarmed = 3'd0,
        StArming   = 3'd1,
        StArmed    = 3'd2,
        StEntry    = 3'd3,
        StAlarm    = 3'd4
    } stateT;

    stateT         stateQ, stateD;
    logic [CW-1:0] cntQ, cntD, cntInc;
    logic [PW-1:0] phaseQ, phaseD;
    logic [3:0]    countQ, countD;
    logic          rejectQ, rejectD;
    logic          flashQ, flashD;
    logic          chimeQ, chimeD;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stateQ  <= StDisarmed;
            cntQ    <= '0;
            phaseQ  <= '0;
            countQ  <= '0;
            rejectQ <= 1'b0;
            flashQ  <= 1'b0;
            chimeQ  <= 1'b0;
        end else begin
            stateQ  <= stateD;
            cntQ    <= cntD;
            phaseQ  <= phaseD;
            countQ  <= countD;
            rejectQ <= rejectD;
            flashQ  <= flashD;
            chimeQ  <= chimeD;
        end
    end

    always_comb begin
        stateD  = stateQ;
        cntInc  = cntQ + CW'(1);
        cntD    = cntQ;
        rejectD = 1'b0;
        if (DisarmRequest) begin
            stateD = StDisarmed;
        end else begin
            case (stateQ)
                StDisarmed: begin
                    if (ArmRequest) begin
                        if (!IgnitionSignalOn && !OpenDoorSign) stateD = StArming;
                        else rejectD = 1'b1;
                    end
                end
                StArming: begin
                    // An open door restarts the exit delay rather than aborting arming.
                    if (IgnitionSignalOn)                  stateD = StDisarmed;
                    else if (OpenDoorSign)                 cntD   = '0;
                    else if (cntQ == CW'(EXIT_DLY - 1))    stateD = StArmed;
                    else                                   cntD   = cntInc;
                end
                StArmed: begin
                    if (IgnitionSignalOn)  stateD = StAlarm;
                    else if (OpenDoorSign) stateD = StEntry;
                end
                StEntry: begin
                    if (IgnitionSignalOn || cntQ == CW'(ENTRY_DLY - 1)) stateD = StAlarm;
                    else                                                cntD   = cntInc;
                end
                StAlarm: begin
                    if (cntQ == CW'(SIREN_LEN - 1)) stateD = StArmed;
                    else                            cntD   = cntInc;
                end
                default: stateD = StDisarmed;
            endcase
        end
        if (stateD != stateQ) cntD = '0;
    end

    always_comb begin
        flashD = 1'b0;
        countD = countQ;
        if (stateD == StAlarm) begin
            flashD = (stateQ == StAlarm) ? ~flashQ : 1'b1;
            if (stateQ != StAlarm && countQ != 4'd15) countD = countQ + 4'd1;
        end
    end

    // Chime follows the state being entered so it never sounds outside DISARMED.
    always_comb begin
        chimeD = 1'b0;
        phaseD = '0;
        if (stateD == StDisarmed && PassiveSignal) begin
            chimeD = (phaseQ < PW'(CHIME_HALF));
            phaseD = (phaseQ == PW'(2 * CHIME_HALF - 1)) ? '0 : phaseQ + PW'(1);
        end
    end

    assign State       = stateQ;
    assign Siren       = (stateQ == StAlarm);
    assign LightsFlash = flashQ;
    assign Chime       = chimeQ;
    assign ArmedLed    = (stateQ == StArming) || (stateQ == StArmed) || (stateQ == StEntry);
    assign ArmReject   = rejectQ;
    assign AlarmCount  = countQ;

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: directed scenarios plus randomized traffic checked
// against a behavioural model built from remaining-time and age counters.
module tb_alarm_controller;

    localparam int EXIT_DLY   = 8;
    localparam int ENTRY_DLY  = 8;
    localparam int SIREN_LEN  = 16;
    localparam int CHIME_HALF = 2;
    localparam int CW         = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       IgnitionSignalOn = 1'b0;
    logic       OpenDoorSign = 1'b0;
    logic       PassiveSignal = 1'b0;
    logic       ArmRequest = 1'b0;
    logic       DisarmRequest = 1'b0;
    logic       Siren, LightsFlash, Chime, ArmedLed, ArmReject;
    logic [3:0] AlarmCount;
    logic [2:0] State;

    always #5 clk = ~clk;

    alarm_controller #(
        .EXIT_DLY  (EXIT_DLY),
        .ENTRY_DLY (ENTRY_DLY),
        .SIREN_LEN (SIREN_LEN),
        .CHIME_HALF(CHIME_HALF),
        .CW        (CW)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .IgnitionSignalOn(IgnitionSignalOn),
        .OpenDoorSign    (OpenDoorSign),
        .PassiveSignal   (PassiveSignal),
        .ArmRequest      (ArmRequest),
        .DisarmRequest   (DisarmRequest),
        .Siren           (Siren),
        .LightsFlash     (LightsFlash),
        .Chime           (Chime),
        .ArmedLed        (ArmedLed),
        .ArmReject       (ArmReject),
        .AlarmCount      (AlarmCount),
        .State           (State)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: mRemain = edges left before the timed exit of the current state.
    int mState = 0, mRemain = 0, mAlarmAge = 0, mChimeAge = 0, mCount = 0;
    bit mReject = 0, mFlash = 0, mChime = 0;

    function automatic void modelStep();
        int nxt;
        if (!reset_n) begin
            mState = 0; mRemain = 0; mAlarmAge = 0; mChimeAge = 0; mCount = 0;
            mReject = 0; mFlash = 0; mChime = 0;
            return;
        end
        nxt = mState;
        mReject = 0;
        if (DisarmRequest) nxt = 0;
        else begin
            case (mState)
                0: if (ArmRequest) begin
                       if (!IgnitionSignalOn && !OpenDoorSign) nxt = 1;
                       else mReject = 1;
                   end
                1: if (IgnitionSignalOn) nxt = 0;
                   else if (OpenDoorSign) mRemain = EXIT_DLY;
                   else if (mRemain == 1) nxt = 2;
                   else mRemain--;
                2: if (IgnitionSignalOn) nxt = 4;
                   else if (OpenDoorSign) nxt = 3;
                3: if (IgnitionSignalOn || mRemain == 1) nxt = 4;
                   else mRemain--;
                default: if (mRemain == 1) nxt = 2;
                   else mRemain--;
            endcase
        end
        if (nxt != mState) begin
            if (nxt == 1) mRemain = EXIT_DLY;
            if (nxt == 3) mRemain = ENTRY_DLY;
            if (nxt == 4) begin
                mRemain = SIREN_LEN;
                mAlarmAge = 0;
                if (mCount < 15) mCount++;
            end
        end else if (nxt == 4) begin
            mAlarmAge++;
        end
        mFlash = (nxt == 4) && (mAlarmAge % 2 == 0);
        if (nxt == 0 && PassiveSignal) begin
            mChime = (mChimeAge % (2 * CHIME_HALF)) < CHIME_HALF;
            mChimeAge++;
        end else begin
            mChime = 0;
            mChimeAge = 0;
        end
        mState = nxt;
    endfunction

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic armUp();
        IgnitionSignalOn = 0; OpenDoorSign = 0;
        ArmRequest = 1; tick(); ArmRequest = 0;
        repeat (EXIT_DLY) tick();
    endtask

    task automatic test_reset();
        reset_n = 0; tick(); tick();
        reset_n = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if ({State, Siren, LightsFlash, Chime, ArmedLed, ArmReject, AlarmCount} !== 12'd0) begin
                miscompares++;
                $display("FAIL reset_idle cycle %0d: got %b expected all zero", i,
                         {State, Siren, LightsFlash, Chime, ArmedLed, ArmReject, AlarmCount});
            end
        end
    endtask

    task automatic test_reject();
        OpenDoorSign = 1; ArmRequest = 1; tick(); ArmRequest = 0;
        vectors++;
        if (ArmReject !== 1'b1 || State !== 3'd0) begin
            miscompares++;
            $display("FAIL reject_pulse: ArmReject=%b State=%0d expected 1/0", ArmReject, State);
        end
        tick();
        vectors++;
        if (ArmReject !== 1'b0) begin
            miscompares++;
            $display("FAIL reject_single: ArmReject=%b expected 0", ArmReject);
        end
        OpenDoorSign = 0;
    endtask

    task automatic test_arm();
        ArmRequest = 1; tick(); ArmRequest = 0;
        vectors++;
        if (ArmedLed !== 1'b1 || State !== 3'd1) begin
            miscompares++;
            $display("FAIL arm_start: ArmedLed=%b State=%0d expected 1/1", ArmedLed, State);
        end
        for (int i = 1; i < EXIT_DLY; i++) begin
            tick();
            vectors++;
            if (State !== 3'd1) begin
                miscompares++;
                $display("FAIL arm_hold %0d: State=%0d expected 1", i, State);
            end
        end
        tick();
        vectors++;
        if (State !== 3'd2 || ArmedLed !== 1'b1) begin
            miscompares++;
            $display("FAIL arm_done: State=%0d ArmedLed=%b expected 2/1", State, ArmedLed);
        end
    endtask

    task automatic test_entry_alarm();
        OpenDoorSign = 1; tick(); OpenDoorSign = 0;
        vectors++;
        if (State !== 3'd3) begin
            miscompares++;
            $display("FAIL entry_start: State=%0d expected 3", State);
        end
        repeat (ENTRY_DLY - 1) tick();
        vectors++;
        if (State !== 3'd3) begin
            miscompares++;
            $display("FAIL entry_hold: State=%0d expected 3", State);
        end
        tick();
        for (int i = 0; i < SIREN_LEN; i++) begin
            vectors++;
            if (State !== 3'd4 || Siren !== 1'b1 || LightsFlash !== logic'(i % 2 == 0)) begin
                miscompares++;
                $display("FAIL siren_cycle %0d: State=%0d Siren=%b Flash=%b expected 4/1/%0d",
                         i, State, Siren, LightsFlash, (i % 2 == 0));
            end
            tick();
        end
        vectors++;
        if (State !== 3'd2 || Siren !== 1'b0 || LightsFlash !== 1'b0 || AlarmCount !== 4'd1) begin
            miscompares++;
            $display("FAIL rearm: State=%0d Siren=%b Flash=%b Count=%0d expected 2/0/0/1",
                     State, Siren, LightsFlash, AlarmCount);
        end
    endtask

    task automatic test_ignition_disarm();
        IgnitionSignalOn = 1; tick(); IgnitionSignalOn = 0;
        vectors++;
        if (State !== 3'd4 || Siren !== 1'b1) begin
            miscompares++;
            $display("FAIL ign_alarm: State=%0d Siren=%b expected 4/1", State, Siren);
        end
        repeat (4) tick();
        DisarmRequest = 1; tick(); DisarmRequest = 0;
        vectors++;
        if (State !== 3'd0 || Siren !== 1'b0 || AlarmCount !== 4'd2) begin
            miscompares++;
            $display("FAIL disarm_alarm: State=%0d Siren=%b Count=%0d expected 0/0/2",
                     State, Siren, AlarmCount);
        end
    endtask

    task automatic test_arm_disarm_same();
        for (int d = 0; d < 2; d++) begin
            OpenDoorSign = logic'(d);
            ArmRequest = 1; DisarmRequest = 1; tick();
            ArmRequest = 0; DisarmRequest = 0;
            vectors++;
            if (State !== 3'd0 || ArmReject !== 1'b0) begin
                miscompares++;
                $display("FAIL arm_disarm door=%0d: State=%0d ArmReject=%b expected 0/0",
                         d, State, ArmReject);
            end
        end
        OpenDoorSign = 0;
    endtask

    task automatic test_chime();
        logic [9:0] pattern;
        pattern = 10'b1100110011;
        PassiveSignal = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (Chime !== pattern[9 - i]) begin
                miscompares++;
                $display("FAIL chime_pattern %0d: Chime=%b expected %b", i, Chime, pattern[9 - i]);
            end
        end
        PassiveSignal = 0; tick();
        vectors++;
        if (Chime !== 1'b0) begin
            miscompares++;
            $display("FAIL chime_drop: Chime=%b expected 0", Chime);
        end
    endtask

    task automatic test_saturate();
        reset_n = 0; tick(); reset_n = 1;
        armUp();
        for (int k = 1; k <= 16; k++) begin
            IgnitionSignalOn = 1; tick(); IgnitionSignalOn = 0;
            vectors++;
            if (AlarmCount !== 4'((k > 15) ? 15 : k)) begin
                miscompares++;
                $display("FAIL alarm_count event %0d: Count=%0d expected %0d", k, AlarmCount,
                         (k > 15) ? 15 : k);
            end
            repeat (SIREN_LEN) tick();
        end
    endtask

    task automatic test_reset_in_alarm();
        IgnitionSignalOn = 1; tick(); IgnitionSignalOn = 0;
        repeat (3) tick();
        reset_n = 0; tick(); reset_n = 1;
        vectors++;
        if (Siren !== 1'b0 || State !== 3'd0 || AlarmCount !== 4'd0 || LightsFlash !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_alarm: Siren=%b State=%0d Count=%0d Flash=%b expected 0/0/0/0",
                     Siren, State, AlarmCount, LightsFlash);
        end
    endtask

    task automatic test_random();
        logic [11:0] got, exp;
        for (int i = 0; i < 3000; i++) begin
            reset_n       = ($urandom_range(0, 299) != 0);
            DisarmRequest = ($urandom_range(0, 39) == 0);
            ArmRequest    = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) IgnitionSignalOn = ~IgnitionSignalOn;
            if ($urandom_range(0, 15) == 0) OpenDoorSign = ~OpenDoorSign;
            if ($urandom_range(0, 11) == 0) PassiveSignal = ~PassiveSignal;
            tick();
            got = {State, Siren, LightsFlash, Chime, ArmedLed, ArmReject, AlarmCount};
            exp = {3'(mState), logic'(mState == 4), logic'(mFlash), logic'(mChime),
                   logic'(mState >= 1 && mState <= 3), logic'(mReject), 4'(mCount)};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL random cycle %0d: got %b expected %b", i, got, exp);
            end
        end
        reset_n = 1; ArmRequest = 0; DisarmRequest = 0;
    endtask

    initial begin
        test_reset();
        test_reject();
        test_arm();
        test_entry_alarm();
        test_ignition_disarm();
        test_arm_disarm_same();
        test_chime();
        test_saturate();
        test_reset_in_alarm();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alarm_controller.md
# alarm_controller

Sequencing controller for the car alarm: one synchronous FSM that arms and disarms the alarm from key-fob requests, applies exit and entry delays, times the siren, and paces the "lights left on" warning chime from the passive-warning signal. It sits above the combinational passive-warning gate, consumes its PassiveSignal output plus the raw car sensors, and drives the siren, flasher, chime and status outputs.

## Interface
- EXIT_DLY, 8: cycles spent in ARMING before ARMED (≥1)
- ENTRY_DLY, 8: cycles spent in ENTRY before ALARM (≥1)
- SIREN_LEN, 16: cycles Siren stays high per alarm event (≥1)
- CHIME_HALF, 2: Chime high/low half-period in cycles (≥1)
- CW, 8: width of the shared delay counter; must hold max(EXIT_DLY, ENTRY_DLY, SIREN_LEN)
- clk  in  1  single clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- IgnitionSignalOn  in  1  ignition on
- OpenDoorSign  in  1  any door open
- PassiveSignal  in  1  lights-on & door-open & ignition-off warning from the passive gate
- ArmRequest  in  1  fob lock, 1-cycle pulse
- DisarmRequest  in  1  fob unlock, 1-cycle pulse
- Siren  out  1  siren drive
- LightsFlash  out  1  hazard flasher, toggles in ALARM
- Chime  out  1  lights-on warning chime
- ArmedLed  out  1  high in ARMING, ARMED, ENTRY
- ArmReject  out  1  1-cycle pulse: arm request refused
- AlarmCount  out  4  alarm events since reset, saturates at 15
- State  out  3  DISARMED=0, ARMING=1, ARMED=2, ENTRY=3, ALARM=4

## Operation
- All outputs registered or decoded from registered state; no input-to-output combinational path.
- One shared counter `cnt`, cleared on every state change.
- DisarmRequest has priority over every other event in every state, and sends the FSM to DISARMED (staying in DISARMED if already there).
- DISARMED: ArmRequest with IgnitionSignalOn=0 and OpenDoorSign=0 → ARMING. ArmRequest otherwise → stay, ArmReject=1 next cycle. ArmRequest and DisarmRequest together → stay, no reject.
- ARMING: cnt increments each cycle; OpenDoorSign=1 clears cnt (exit delay restarts); IgnitionSignalOn=1 → DISARMED; cnt = EXIT_DLY-1 → ARMED.
- ARMED: IgnitionSignalOn=1 → ALARM (takes precedence over the door); OpenDoorSign=1 → ENTRY.
- ENTRY: cnt increments; IgnitionSignalOn=1 → ALARM immediately; cnt = ENTRY_DLY-1 → ALARM. Closing the door does not cancel ENTRY.
- ALARM: Siren=1; LightsFlash toggles every cycle, starting at 1; cnt = SIREN_LEN-1 → ARMED (re-arm). Entry into ALARM increments AlarmCount (saturating).
- Chime: active only while State=DISARMED and PassiveSignal=1; pattern is CHIME_HALF cycles high, CHIME_HALF cycles low, repeating, starting high. PassiveSignal=0 or leaving DISARMED → Chime=0 next cycle and phase reset.
- Siren, LightsFlash = 0 outside ALARM.

## Timing
- Reset (reset_n=0 at an edge): State=DISARMED, cnt=0, AlarmCount=0, Siren=LightsFlash=Chime=ArmedLed=ArmReject=0. Reset applies mid-alarm too: Siren drops after that edge.
- ArmRequest sampled at edge N → State=ARMING after N; State=ARMED after edge N+EXIT_DLY (no door events).
- Door opens in ARMED at edge M → ENTRY after M; ALARM after M+ENTRY_DLY.
- Siren high for exactly SIREN_LEN cycles, then ARMED.
- DisarmRequest at edge K → State=DISARMED, Siren=0 after K.
- ArmReject: high for exactly the one cycle following the refused request.

## Test plan
- Reset then idle 5 cycles → State=0, all outputs 0, AlarmCount=0.
- ArmRequest, doors closed, ignition off, EXIT_DLY=8 → ArmedLed=1 next cycle, State=2 exactly 8 cycles after the request; ArmRequest with door open → ArmReject single-cycle pulse, State stays 0.
- Armed, OpenDoorSign pulse, no disarm → State=3 then State=4 after 8 cycles; Siren high 16 cycles, LightsFlash 1,0,1,…, then State=2, AlarmCount=1.
- Armed, IgnitionSignalOn=1 → State=4 next cycle; DisarmRequest in cycle 5 of siren → State=0, Siren=0 next cycle; simultaneous Arm+Disarm in DISARMED → no state change, no reject.
- DISARMED, PassiveSignal=1 for 10 cycles, CHIME_HALF=2 → Chime 1,1,0,0,1,1,0,0,1,1; drop PassiveSignal → Chime=0 next cycle.
- 16 alarm events → AlarmCount saturates at 15; reset_n=0 during ALARM → Siren=0, State=0 after that edge.
